// File: rtl/sx_axis_pkg.sv
// rtl/sx_axis_pkg.sv - Arbiter state type, counter width and round-robin pick function
package sx_axis_pkg;

    localparam int MAX_PORTS     = 16;
    localparam int PKT_CNT_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // First requester strictly after last, wrapping at n_ports; returns last when nobody requests.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [3:0]           last,
        input int                   n_ports
    );
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            idx = 4'((int'(last) + i) % n_ports);
            if (i <= n_ports && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sx_axis_skid.sv
// rtl/sx_axis_skid.sv - Two-entry skid buffer decoupling the arbiter mux from downstream ready
module sx_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] skid_data;
    logic             out_valid;
    logic             skid_valid;
    logic             s_fire;

    assign s_tready = !skid_valid;
    assign s_fire   = s_tvalid && s_tready;
    assign m_tdata  = out_data;
    assign m_tvalid = out_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_data   <= '0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (m_tready || !out_valid) begin
            // Output slot frees up: a parked beat always goes before a new one.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (s_fire) begin
                out_data  <= s_tdata;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (s_fire) begin
            skid_data  <= s_tdata;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/sx_axis_arbiter.sv
// rtl/sx_axis_arbiter.sv - Packet-level round-robin AXI-Stream arbiter; SX_ARB_PKT_CNT_EN adds per-port packet counters
module sx_axis_arbiter
    import sx_axis_pkg::*;
#(
    parameter int  N_PORTS    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  ID_WIDTH   = 32,
    parameter int  DEST_WIDTH = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [N_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep_i,
    input  logic [N_PORTS*ID_WIDTH-1:0]   s_axis_tid_i,
    input  logic [N_PORTS*DEST_WIDTH-1:0] s_axis_tdest_i,
    input  logic [N_PORTS-1:0]            s_axis_tvalid_i,
    input  logic [N_PORTS-1:0]            s_axis_tlast_i,
    output logic [N_PORTS-1:0]            s_axis_tready_o,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep_o,
    output logic [ID_WIDTH-1:0]           m_axis_tid_o,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest_o,
    output logic                          m_axis_tvalid_o,
    output logic                          m_axis_tlast_o,
    input  logic                          m_axis_tready_i,
    output logic [N_PORTS-1:0]            grant_o,
`ifdef SX_ARB_PKT_CNT_EN
    output logic [N_PORTS*PKT_CNT_WIDTH-1:0] pkt_cnt_o,
`endif
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + 1;

    arb_state_e       state, state_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  skid_ready;
    logic                  beat_fire;
    logic                  last_fire;
    logic [PAY_W-1:0]      skid_out;

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_id    = '0;
        sel_dest  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant_idx == IDX_W'(p)) begin
                sel_data  = s_axis_tdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep_i[p*KEEP_WIDTH +: KEEP_WIDTH];
                sel_id    = s_axis_tid_i[p*ID_WIDTH +: ID_WIDTH];
                sel_dest  = s_axis_tdest_i[p*DEST_WIDTH +: DEST_WIDTH];
                sel_valid = s_axis_tvalid_i[p];
                sel_last  = s_axis_tlast_i[p];
            end
        end
    end

    assign beat_fire = (state == BUSY) && sel_valid && skid_ready;
    assign last_fire = beat_fire && sel_last;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|s_axis_tvalid_i) state_next = BUSY;
            BUSY:    if (last_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(N_PORTS - 1);
        end else begin
            state <= state_next;
            if (state == IDLE && |s_axis_tvalid_i) begin
                grant_idx <= IDX_W'(rr_pick(MAX_PORTS'(s_axis_tvalid_i), 4'(last_grant), N_PORTS));
            end
            if (last_fire) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_comb begin
        grant_o         = '0;
        s_axis_tready_o = '0;
        if (state == BUSY) begin
            grant_o[grant_idx]         = 1'b1;
            s_axis_tready_o[grant_idx] = skid_ready;
        end
    end

    assign busy_o = (state == BUSY);

    sx_axis_skid #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk     (clk),
        .resetn  (~reset),
        .s_tdata ({sel_last, sel_dest, sel_id, sel_keep, sel_data}),
        .s_tvalid((state == BUSY) && sel_valid),
        .s_tready(skid_ready),
        .m_tdata (skid_out),
        .m_tvalid(m_axis_tvalid_o),
        .m_tready(m_axis_tready_i)
    );

    assign {m_axis_tlast_o, m_axis_tdest_o, m_axis_tid_o, m_axis_tkeep_o, m_axis_tdata_o} = skid_out;

`ifdef SX_ARB_PKT_CNT_EN
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt [N_PORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                pkt_cnt[p] <= '0;
            end
        end else if (last_fire) begin
            pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + PKT_CNT_WIDTH'(1);
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt_out
        assign pkt_cnt_o[p*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = pkt_cnt[p];
    end
`endif

endmodule

// File: tb/tb_sx_axis_arbiter.sv
// tb/tb_sx_axis_arbiter.sv - Directed vector table plus packet-level sequences for sx_axis_arbiter
module tb_sx_axis_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IW  = 32;
    localparam int DSW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*IW-1:0]  s_tid;
    logic [NP*DSW-1:0] s_tdest;
    logic [NP-1:0]   s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IW-1:0]   m_tid;
    logic [DSW-1:0]  m_tdest;
    logic            m_tvalid, m_tlast, m_tready;
    logic [NP-1:0]   grant;
    logic            busy;
`ifdef SX_ARB_PKT_CNT_EN
    logic [NP*16-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    sx_axis_arbiter #(
        .N_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tid_i(s_tid),
        .s_axis_tdest_i(s_tdest), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
        .s_axis_tready_o(s_tready),
        .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tid_o(m_tid),
        .m_axis_tdest_o(m_tdest), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
        .m_axis_tready_i(m_tready),
        .grant_o(grant),
`ifdef SX_ARB_PKT_CNT_EN
        .pkt_cnt_o(pkt_cnt),
`endif
        .busy_o(busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic [3:0]  e_srdy;
        logic        e_mval;
        logic [31:0] e_data;
    } vec_t;

    localparam logic [31:0] D0 = 32'hC0DE_0000;
    localparam logic [31:0] D1 = 32'hC0DE_0001;
    localparam logic [31:0] D2 = 32'hC0DE_0002;
    localparam logic [31:0] D3 = 32'hC0DE_0003;

    vec_t vecs [17];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seq = 0;

    logic [36:0] src   [NP][$];
    logic [32:0] exp_q [NP][$];
    int          gap_cnt [NP];
    logic [NP-1:0] fired;
    int          out_order[$];
    logic [3:0]  grant_seen[$];
    logic        busy_trace[$];
    bit          use_bp = 1'b0;
    bit          trace_on = 1'b0;
    bit          p1_done, p2_early;
    int          m_first, m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_raw(input int p, input logic [31:0] data, input logic last, input int gap);
        src[p].push_back({4'(gap), last, data});
        exp_q[p].push_back({last, data});
    endtask

    task automatic add_packet(input int p, input int nbeats, input int gap_beat, input int gap_len);
        for (int b = 0; b < nbeats; b++) begin
            add_raw(p, {8'(p), 24'(seq)}, b == nbeats - 1, (b == gap_beat) ? gap_len : 0);
            seq++;
        end
    endtask

    function automatic bit all_done();
        for (int p = 0; p < NP; p++) begin
            if (src[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (src[p].size() > 0 && gap_cnt[p] == 0) begin
                s_tvalid[p] = 1'b1;
                s_tlast[p]  = src[p][0][32];
                s_tdata[p*DW +: DW] = src[p][0][31:0];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tlast[p]  = 1'b0;
                if (gap_cnt[p] > 0) gap_cnt[p]--;
            end
        end
        m_tready = use_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic sink();
        int port;
        logic [32:0] e;
        port = int'(m_tid);
        if (port < 0 || port >= NP) begin
            check("out_tid_range", 64'(m_tid), 64'(0));
            return;
        end
        if (exp_q[port].size() == 0) begin
            check($sformatf("p%0d unexpected beat", port), {m_tlast, m_tdata}, 64'(0));
            return;
        end
        e = exp_q[port].pop_front();
        check($sformatf("p%0d beat", port), {m_tlast, m_tdata}, e);
        check($sformatf("p%0d dest", port), 64'(m_tdest), 64'(port + 16));
        if (m_first < 0) m_first = cyc;
        m_last = cyc;
        if (port == 2 && !p1_done) p2_early = 1'b1;
        if (m_tlast) begin
            out_order.push_back(port);
            if (port == 1) p1_done = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (trace_on) busy_trace.push_back(busy);
        fired = s_tvalid & s_tready;
        for (int p = 0; p < NP; p++) begin
            if (fired[p] && s_tlast[p]) grant_seen.push_back(grant);
        end
        if (m_tvalid && m_tready) sink();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (fired[p]) begin
                void'(src[p].pop_front());
                if (src[p].size() > 0) gap_cnt[p] = int'(src[p][0][36:33]);
            end
        end
        drive();
        cyc++;
    endtask

    task automatic run(input int max_cyc);
        int n = 0;
        while (!all_done() && n < max_cyc) begin
            cycle();
            n++;
        end
        check("run_complete", 64'(all_done()), 64'(1));
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        for (int p = 0; p < NP; p++) begin
            src[p].delete();
            exp_q[p].delete();
            gap_cnt[p] = 0;
        end
        out_order.delete();
        grant_seen.delete();
        busy_trace.delete();
        p1_done  = 1'b0;
        p2_early = 1'b0;
        m_first  = -1;
        m_last   = -1;
        reset    = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        s_tvalid = 4'hF;
        s_tlast  = 4'hF;
        m_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            s_tdata[p*DW +: DW]   = D0 + 32'(p);
            s_tkeep[p*KW +: KW]   = '1;
            s_tid[p*IW +: IW]     = IW'(p);
            s_tdest[p*DSW +: DSW] = DSW'(p + 16);
        end

        vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, D0};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 4'h2, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, D1};
        vecs[7]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, D1};
        vecs[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, D1};
        vecs[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 1'b1, 4'h8, 1'b1, D2};
        vecs[10] = '{1'b0, 4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 4'h8, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, D3};
        vecs[12] = '{1'b0, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, D0};
        vecs[15] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};

        @(posedge clk);
        #1;
        // Each row's expectations are the registered outputs left by the previous rows.
        for (int i = 0; i < 17; i++) begin
            reset    = vecs[i].rst;
            s_tvalid = vecs[i].tv;
            s_tlast  = vecs[i].tl;
            m_tready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
            check($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("row%0d s_tready", i), 64'(s_tready), 64'(vecs[i].e_srdy));
            check($sformatf("row%0d m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].e_mval));
            if (vecs[i].e_mval) check($sformatf("row%0d m_tdata", i), 64'(m_tdata), 64'(vecs[i].e_data));
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) add_packet(p, 2, -1, 0);
        end
        drive();
        run(200);
        check("rot_pkt_count", 64'(out_order.size()), 64'(8));
        if (out_order.size() >= 5 && grant_seen.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rot_order%0d", k), 64'(out_order[k]), 64'(k % 4));
                check($sformatf("rot_grant%0d", k), 64'(grant_seen[k]), 64'(4'b0001 << (k % 4)));
            end
        end
        check("rot_output_span", 64'(m_last - m_first), 64'(22));

        do_reset();
        add_packet(1, 5, 2, 3);
        add_packet(2, 2, -1, 0);
        drive();
        run(200);
        check("lock_no_early_p2", 64'(p2_early), 64'(0));
        check("lock_pkt_count", 64'(out_order.size()), 64'(2));
        if (out_order.size() == 2) begin
            check("lock_first_owner", 64'(out_order[0]), 64'(1));
            check("lock_second_owner", 64'(out_order[1]), 64'(2));
        end

        do_reset();
        use_bp = 1'b1;
        for (int k = 0; k < 100; k++) begin
            add_packet($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 7), $urandom_range(0, 2));
        end
        drive();
        run(20000);
        use_bp = 1'b0;
        check("bp_pkt_count", 64'(out_order.size()), 64'(100));

        do_reset();
        for (int k = 0; k < 4; k++) add_raw(3, 32'hA5A5A5A5, 1'b1, 0);
        trace_on = 1'b1;
        drive();
        run(100);
        trace_on = 1'b0;
        check("single_pkt_count", 64'(out_order.size()), 64'(4));
        begin
            int i0 = -1;
            int ones = 0;
            for (int k = 0; k < busy_trace.size(); k++) begin
                if (busy_trace[k]) ones++;
                if (busy_trace[k] && i0 < 0) i0 = k;
            end
            check("single_busy_pulses", 64'(ones), 64'(4));
            if (i0 >= 0 && i0 + 7 <= busy_trace.size()) begin
                for (int k = 0; k < 7; k++) begin
                    check($sformatf("single_busy_pattern%0d", k), 64'(busy_trace[i0 + k]), 64'(k % 2 == 0));
                end
            end else begin
                check("single_busy_trace_len", 64'(busy_trace.size()), 64'(i0 + 7));
            end
        end

`ifdef SX_ARB_PKT_CNT_EN
        do_reset();
        begin
            int n = 0;
            int budget = 0;
            s_tvalid = 4'b0001;
            s_tlast  = 4'b0001;
            while (n < 65537 && budget < 140000) begin
                @(negedge clk);
                if (s_tvalid[0] && s_tready[0]) n++;
                @(posedge clk);
                #1;
                if (n == 65537) s_tvalid = '0;
                budget++;
            end
            s_tvalid = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("cnt_packets_sent", 64'(n), 64'(65537));
            check("cnt_wrap_port0", 64'(pkt_cnt[15:0]), 64'(1));
            check("cnt_port1_idle", 64'(pkt_cnt[31:16]), 64'(0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sx_axis_arbiter.md
SX_AXIS_ARBITER -- requirements
Module: sx_axis_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, meaning number of slave inputs (2..16).
REQ-002 SHALL have parameters DATA_WIDTH/ID_WIDTH/DEST_WIDTH, default 32 each; KEEP_WIDTH = DATA_WIDTH/8 is derived, not overridable.
REQ-003 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); one clock, reset synchronous active-high.
REQ-004 SHALL have s_axis_tdata_i/tkeep_i/tid_i/tdest_i (in, N_PORTS x field width, packed per port) and s_axis_tvalid_i/tlast_i (in, N_PORTS).
REQ-005 SHALL have s_axis_tready_o (out, N_PORTS, per-port ready).
REQ-006 SHALL have m_axis_tdata_o/tkeep_o/tid_o/tdest_o/tvalid_o/tlast_o (out, widths as one port) and m_axis_tready_i (in, 1).
REQ-007 SHALL have grant_o (out, N_PORTS, one-hot current owner, zero when idle) and busy_o (out, 1, packet in flight).

Function
REQ-008 SHALL arbitrate whole packets: once granted, a port owns the output until its tlast beat is accepted.
REQ-009 SHALL use FSM states IDLE and BUSY; IDLE->BUSY when any s_axis_tvalid_i is high; BUSY->IDLE on accepted beat with tlast=1.
REQ-010 SHALL pick the winner in IDLE round-robin: first requesting port strictly after last_grant, wrapping N_PORTS-1 -> 0; last_grant after reset = N_PORTS-1 (port 0 wins first).
REQ-011 SHALL register the grant; first beat of a packet is forwarded in the cycle after the IDLE arbitration cycle (one bubble per packet).
REQ-012 SHALL in BUSY drive s_axis_tready_o[g] = skid input ready, all other ready bits 0; in IDLE all ready bits 0.
REQ-013 SHALL forward only the granted port's fields into the output skid stage; non-granted tvalid is ignored.
REQ-014 SHALL update last_grant only on the tlast handshake, so back-to-back packets from multiple requesters rotate fairly.
REQ-015 SHALL NOT drop or reorder beats under arbitrary m_axis_tready_i backpressure; full throughput (1 beat/cycle) inside a packet when ready held high.
REQ-016 SHALL keep ownership if the granted port drops tvalid mid-packet (no timeout, no preemption).
REQ-017 SHALL treat a single-beat packet (tlast on first beat) as BUSY for one accepted beat, then IDLE.
REQ-018 SHALL ignore requests that appear in the tlast cycle until the next IDLE cycle.

Reset
REQ-019 SHALL on reset force state IDLE, grant_o=0, busy_o=0, s_axis_tready_o=0, m_axis_tvalid_o=0, last_grant=N_PORTS-1, counters 0.
REQ-020 SHALL on reset mid-packet discard the partial packet and skid contents; no beat is emitted the cycle after reset deasserts.

Configuration
REQ-021 SHALL compile per-port packet counters when SX_ARB_PKT_CNT_EN is defined: output pkt_cnt_o (N_PORTS x 16), incremented on each accepted tlast beat of that port, wrapping 0xFFFF->0.
REQ-022 SHALL omit pkt_cnt_o and all counter logic when SX_ARB_PKT_CNT_EN is undefined; all other behaviour identical.

Structure
REQ-023 SHALL place state enum (IDLE, BUSY), PKT_CNT_WIDTH=16 and the round-robin pick function in package sx_axis_pkg.
REQ-024 SHALL instantiate one output skid buffer sub-module sx_axis_skid (active-low reset driven by ~reset) between mux and m_axis.

Verification
REQ-025 Reset: hold reset 3 cycles with all tvalid=1 -> all outputs 0 during reset, first grant_o=4'b0001 after release.
REQ-026 Rotation: ports 0..3 each send 2-beat packets continuously, ready=1 -> output packet order 0,1,2,3,0 with grant_o 1,2,4,8,1.
REQ-027 Lock: port 1 sends 5-beat packet with tvalid gap of 3 cycles at beat 2, port 2 requesting -> no port-2 beat until port-1 tlast accepted.
REQ-028 Backpressure: random m_axis_tready_i 50%, 100 packets of 1..8 beats on all ports -> scoreboard exact per-port data order, zero loss.
REQ-029 Single-beat: port 3 alone sends tlast-only beats 0xA5A5A5A5 x4 -> 4 output beats, busy_o pulses, each packet separated by one idle cycle.
REQ-030 With SX_ARB_PKT_CNT_EN: port 0 sends 65537 one-beat packets -> pkt_cnt_o[0]=1; without macro the bench compiles with no pkt_cnt_o.
